// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - in-order allocate, out-of-order writeback, in-order commit scoreboard
//
// ariane_pkg carries the scoreboard record types shared with issue and commit.
//
// issue_scoreboard ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                discard every entry (wins over issue/writeback/commit)
//   issue_valid_i          allocate request; issue_entry_i supplies fu/op/rs1/rs2/rd
//   issue_ready_o          buffer has a free slot
//   issue_trans_id_o       ID the next allocation takes (tail pointer)
//   rs1_i, rs2_i           hazard query registers
//   rsX_busy_o             youngest writer of rsX still in flight
//   rsX_fwd_valid_o/_o     youngest writer of rsX has written back, and its result
//   wb_valid_i             writeback strobe for wb_trans_id_i with wb_result_i / wb_ex_i
//   commit_valid_o         head entry has its result
//   commit_entry_o         head record, driven regardless of commit_valid_o
//   commit_ack_i           retire the head entry
package ariane_pkg;
    typedef enum logic [2:0] {
        FU_NONE = 3'd0,
        FU_ALU  = 3'd1,
        FU_MULT = 3'd2,
        FU_LSU  = 3'd3,
        FU_CSR  = 3'd4
    } fu_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        fu_t         fu;
        logic [7:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] result;
        logic        valid;
        logic        in_flight;
        exception_t  ex;
    } scoreboard_entry_t;
endpackage

module issue_scoreboard
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES    = 8,
    localparam int unsigned TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    input  scoreboard_entry_t        issue_entry_i,
    output logic                     issue_ready_o,
    output logic [TRANS_ID_BITS-1:0] issue_trans_id_o,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    output logic                     rs1_busy_o,
    output logic                     rs2_busy_o,
    output logic                     rs1_fwd_valid_o,
    output logic                     rs2_fwd_valid_o,
    output logic [63:0]              rs1_fwd_o,
    output logic [63:0]              rs2_fwd_o,
    input  logic                     wb_valid_i,
    input  logic [TRANS_ID_BITS-1:0] wb_trans_id_i,
    input  logic [63:0]              wb_result_i,
    input  exception_t               wb_ex_i,
    output logic                     commit_valid_o,
    output scoreboard_entry_t        commit_entry_o,
    input  logic                     commit_ack_i
);
    localparam logic [TRANS_ID_BITS:0] FULL_COUNT = (TRANS_ID_BITS + 1)'(NR_ENTRIES);

    typedef struct packed {
        logic        busy;
        logic        fwd_valid;
        logic [63:0] fwd;
    } hazard_t;

    scoreboard_entry_t        mem_q [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]    alloc_q;
    logic [TRANS_ID_BITS-1:0] head_q;
    logic [TRANS_ID_BITS-1:0] tail_q;
    logic [TRANS_ID_BITS:0]   count_q;

    logic              issue_fire;
    logic              wb_fire;
    logic              commit_fire;
    scoreboard_entry_t issue_rec;
    hazard_t           haz1;
    hazard_t           haz2;

    // Ready comes from the registered count only, so a full buffer stays
    // closed for the cycle in which commit frees a slot.
    assign issue_ready_o    = (count_q < FULL_COUNT);
    assign issue_trans_id_o = tail_q;
    assign issue_fire       = issue_valid_i & issue_ready_o;

    // A slot being issued this cycle is not yet allocated, so a writeback
    // aimed at it is dropped here.
    assign wb_fire = wb_valid_i & alloc_q[wb_trans_id_i] & mem_q[wb_trans_id_i].in_flight;

    assign commit_entry_o = mem_q[head_q];
    assign commit_valid_o = alloc_q[head_q] & mem_q[head_q].valid;
    assign commit_fire    = commit_ack_i & commit_valid_o;

    always_comb begin
        issue_rec           = issue_entry_i;
        issue_rec.result    = '0;
        issue_rec.valid     = 1'b0;
        issue_rec.in_flight = 1'b1;
        issue_rec.ex        = '0;
    end

    // Allocated entries are contiguous from head, so walking in age order
    // and letting each later match overwrite leaves the youngest writer.
    function automatic hazard_t lookup(input logic [4:0] rs);
        hazard_t                  h;
        logic [TRANS_ID_BITS-1:0] idx;
        h = '0;
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            idx = head_q + TRANS_ID_BITS'(i);
            if (alloc_q[idx] && (mem_q[idx].rd == rs)) begin
                h.busy      = mem_q[idx].in_flight;
                h.fwd_valid = mem_q[idx].valid;
                h.fwd       = mem_q[idx].result;
            end
        end
        if (rs == 5'd0) begin
            h = '0;
        end
        return h;
    endfunction

    always_comb begin
        haz1 = lookup(rs1_i);
        haz2 = lookup(rs2_i);
    end

    assign rs1_busy_o      = haz1.busy;
    assign rs1_fwd_valid_o = haz1.fwd_valid;
    assign rs1_fwd_o       = haz1.fwd;
    assign rs2_busy_o      = haz2.busy;
    assign rs2_fwd_valid_o = haz2.fwd_valid;
    assign rs2_fwd_o       = haz2.fwd;

    // Issue writes the tail slot and commit frees the head slot; they can only
    // coincide when empty or full, where one of the two cannot fire.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
            alloc_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            // Records are zeroed too so commit_entry_o reads all zeros afterwards.
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
            alloc_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (issue_fire) begin
                mem_q[tail_q]   <= issue_rec;
                alloc_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (wb_fire) begin
                mem_q[wb_trans_id_i].result    <= wb_result_i;
                mem_q[wb_trans_id_i].ex        <= wb_ex_i;
                mem_q[wb_trans_id_i].valid     <= 1'b1;
                mem_q[wb_trans_id_i].in_flight <= 1'b0;
            end
            if (commit_fire) begin
                alloc_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            case ({issue_fire, commit_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - self-checking bench for issue_scoreboard
module tb_issue_scoreboard;
    import ariane_pkg::*;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              flush;
    logic              issue_valid;
    scoreboard_entry_t issue_entry;
    logic              issue_ready;
    logic [2:0]        issue_tid;
    logic [4:0]        rs1, rs2;
    logic              rs1_busy, rs2_busy, rs1_fv, rs2_fv;
    logic [63:0]       rs1_fwd, rs2_fwd;
    logic              wb_valid;
    logic [2:0]        wb_id;
    logic [63:0]       wb_result;
    exception_t        wb_ex;
    logic              commit_valid;
    scoreboard_entry_t commit_entry;
    logic              commit_ack;

    int checks   = 0;
    int failures = 0;

    issue_scoreboard #(.NR_ENTRIES(8)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
        .issue_valid_i(issue_valid), .issue_entry_i(issue_entry),
        .issue_ready_o(issue_ready), .issue_trans_id_o(issue_tid),
        .rs1_i(rs1), .rs2_i(rs2),
        .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
        .rs1_fwd_valid_o(rs1_fv), .rs2_fwd_valid_o(rs2_fv),
        .rs1_fwd_o(rs1_fwd), .rs2_fwd_o(rs2_fwd),
        .wb_valid_i(wb_valid), .wb_trans_id_i(wb_id),
        .wb_result_i(wb_result), .wb_ex_i(wb_ex),
        .commit_valid_o(commit_valid), .commit_entry_o(commit_entry),
        .commit_ack_i(commit_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_entry = '0;
        wb_valid    = 1'b0;
        wb_id       = '0;
        wb_result   = '0;
        wb_ex       = '0;
        commit_ack  = 1'b0;
        rs1         = '0;
        rs2         = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        issue_valid        = 1'b1;
        issue_entry        = '0;
        issue_entry.fu     = FU_ALU;
        issue_entry.rd     = rd;
        issue_entry.result = 64'hBAD0BAD0;
    endtask

    task automatic writeback(input logic [2:0] id, input logic [63:0] res);
        wb_valid  = 1'b1;
        wb_id     = id;
        wb_result = res;
        wb_ex     = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 64'(issue_ready), 64'd1);
        check({tag, "_tid"}, 64'(issue_tid), 64'd0);
        check({tag, "_cvalid"}, 64'(commit_valid), 64'd0);
        check({tag, "_centry_zero"}, 64'(commit_entry == '0), 64'd1);
        check({tag, "_rs1_busy"}, 64'(rs1_busy), 64'd0);
        check({tag, "_rs1_fv"}, 64'(rs1_fv), 64'd0);
        check({tag, "_rs2_busy"}, 64'(rs2_busy), 64'd0);
        check({tag, "_rs1_fwd"}, rs1_fwd, 64'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int iv; int rd; int wv; int wid; logic [63:0] wres; int ack; int q1; int q2;
        int e_ready; int e_tid; int e_cv; logic [63:0] e_cres;
        int e_b1; int e_v1; logic [63:0] e_f1;
        int e_b2; int e_v2; logic [63:0] e_f2;
    } vec_t;
    vec_t vecs [12];

    // ---------------- reference model ----------------
    typedef struct {
        int          id;
        fu_t         fu;
        logic [7:0]  op;
        logic [4:0]  rd;
        bit          done;
        logic [63:0] result;
        exception_t  ex;
    } m_ent_t;
    m_ent_t mq [$];
    int     m_tail;

    function automatic void m_query(input logic [4:0] rs, output logic b, output logic v,
                                    output logic [63:0] f);
        b = 1'b0; v = 1'b0; f = '0;
        if (rs != 5'd0) begin
            foreach (mq[i]) begin
                if (mq[i].rd == rs) begin
                    b = !mq[i].done;
                    v = mq[i].done;
                    f = mq[i].done ? mq[i].result : 64'd0;
                end
            end
        end
    endfunction

    task automatic m_step();
        int     n;
        bit     cfire;
        m_ent_t e;
        if (flush) begin
            mq.delete();
            m_tail = 0;
        end else begin
            n     = mq.size();
            cfire = (n > 0) && mq[0].done && commit_ack;
            if (wb_valid) begin
                foreach (mq[i]) begin
                    if (mq[i].id == int'(wb_id) && !mq[i].done) begin
                        mq[i].done   = 1'b1;
                        mq[i].result = wb_result;
                        mq[i].ex     = wb_ex;
                    end
                end
            end
            if (cfire) void'(mq.pop_front());
            if (issue_valid && n < 8) begin
                e.id = m_tail; e.fu = issue_entry.fu; e.op = issue_entry.op;
                e.rd = issue_entry.rd; e.done = 1'b0; e.result = '0; e.ex = '0;
                mq.push_back(e);
                m_tail = (m_tail + 1) % 8;
            end
        end
    endtask

    logic        eb, ev;
    logic [63:0] ef;

    initial begin
        //       iv rd wv wid wres     ack q1 q2 | rdy tid cv cres     b1 v1 f1       b2 v2 f2
        vecs[0]  = '{1, 5, 0, 0, 64'h0,  0, 5, 0,  1, 1, 0, 64'h0,  1, 0, 64'h0,  0, 0, 64'h0};
        vecs[1]  = '{1, 6, 0, 0, 64'h0,  0, 6, 5,  1, 2, 0, 64'h0,  1, 0, 64'h0,  1, 0, 64'h0};
        vecs[2]  = '{1, 7, 0, 0, 64'h0,  0, 6, 7,  1, 3, 0, 64'h0,  1, 0, 64'h0,  1, 0, 64'h0};
        vecs[3]  = '{0, 0, 1, 2, 64'hC,  0, 7, 6,  1, 3, 0, 64'h0,  0, 1, 64'hC,  1, 0, 64'h0};
        vecs[4]  = '{0, 0, 1, 0, 64'hA,  0, 5, 7,  1, 3, 1, 64'hA,  0, 1, 64'hA,  0, 1, 64'hC};
        vecs[5]  = '{0, 0, 0, 0, 64'h0,  1, 7, 5,  1, 3, 0, 64'h0,  0, 1, 64'hC,  0, 0, 64'h0};
        vecs[6]  = '{1, 3, 0, 0, 64'h0,  0, 3, 6,  1, 4, 0, 64'h0,  1, 0, 64'h0,  1, 0, 64'h0};
        vecs[7]  = '{1, 3, 1, 3, 64'h11, 0, 3, 3,  1, 5, 0, 64'h0,  1, 0, 64'h0,  1, 0, 64'h0};
        vecs[8]  = '{0, 0, 1, 4, 64'h22, 0, 0, 3,  1, 5, 0, 64'h0,  0, 0, 64'h0,  0, 1, 64'h22};
        vecs[9]  = '{0, 0, 1, 1, 64'h66, 0, 6, 3,  1, 5, 1, 64'h66, 0, 1, 64'h66, 0, 1, 64'h22};
        vecs[10] = '{0, 0, 0, 0, 64'h0,  1, 6, 7,  1, 5, 1, 64'hC,  0, 0, 64'h0,  0, 1, 64'hC};
        vecs[11] = '{0, 0, 1, 1, 64'h99, 0, 6, 7,  1, 5, 1, 64'hC,  0, 0, 64'h0,  0, 1, 64'hC};

        rst_ni = 1'b0;
        idle();
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_ni = 1'b1;
        tick();

        foreach (vecs[k]) begin
            idle();
            if (vecs[k].iv != 0) issue_rd(5'(vecs[k].rd));
            if (vecs[k].wv != 0) writeback(3'(vecs[k].wid), vecs[k].wres);
            commit_ack = (vecs[k].ack != 0);
            rs1 = 5'(vecs[k].q1);
            rs2 = 5'(vecs[k].q2);
            tick();
            check($sformatf("vec%0d_ready", k), 64'(issue_ready), 64'(vecs[k].e_ready));
            check($sformatf("vec%0d_tid", k), 64'(issue_tid), 64'(vecs[k].e_tid));
            check($sformatf("vec%0d_cvalid", k), 64'(commit_valid), 64'(vecs[k].e_cv));
            if (vecs[k].e_cv != 0)
                check($sformatf("vec%0d_cresult", k), commit_entry.result, vecs[k].e_cres);
            check($sformatf("vec%0d_rs1_busy", k), 64'(rs1_busy), 64'(vecs[k].e_b1));
            check($sformatf("vec%0d_rs1_fv", k), 64'(rs1_fv), 64'(vecs[k].e_v1));
            check($sformatf("vec%0d_rs1_fwd", k), rs1_fwd, vecs[k].e_f1);
            check($sformatf("vec%0d_rs2_busy", k), 64'(rs2_busy), 64'(vecs[k].e_b2));
            check($sformatf("vec%0d_rs2_fv", k), 64'(rs2_fv), 64'(vecs[k].e_v2));
            check($sformatf("vec%0d_rs2_fwd", k), rs2_fwd, vecs[k].e_f2);
        end

        // Entries 2..4 are pending; add two more for five, then flush with an issue.
        idle(); issue_rd(5'd12); tick();
        idle(); issue_rd(5'd13); tick();
        idle(); issue_rd(5'd14); flush = 1'b1; rs1 = 5'd3; rs2 = 5'd12;
        tick();
        check_idle_outputs("flush");

        // Fill all eight slots; the tail wraps back to 0.
        for (int i = 0; i < 8; i++) begin
            idle();
            check($sformatf("fill_tid%0d", i), 64'(issue_tid), 64'(i));
            issue_rd(5'(i + 1));
            tick();
        end
        idle();
        check("full_ready", 64'(issue_ready), 64'd0);
        check("full_tid_wrap", 64'(issue_tid), 64'd0);
        writeback(3'd0, 64'h5);
        tick();
        idle(); issue_rd(5'd20); commit_ack = 1'b1;
        check("full_ack_ready_low", 64'(issue_ready), 64'd0);
        check("full_ack_cvalid", 64'(commit_valid), 64'd1);
        tick();
        idle();
        check("after_ack_ready", 64'(issue_ready), 64'd1);
        check("after_ack_tid", 64'(issue_tid), 64'd0);
        check("after_ack_cvalid", 64'(commit_valid), 64'd0);
        issue_rd(5'd21);
        tick();
        idle();
        check("stream_tid", 64'(issue_tid), 64'd1);
        check("stream_ready", 64'(issue_ready), 64'd0);

        // Exception carried through to commit; rs 0 never reports busy.
        flush = 1'b1; tick();
        idle(); issue_rd(5'd0); tick();
        idle(); issue_rd(5'd9); tick();
        idle(); issue_rd(5'd10); tick();
        idle();
        check("x0_busy", 64'(rs1_busy), 64'd0);
        commit_ack = 1'b1;
        wb_valid = 1'b1; wb_id = 3'd2; wb_result = 64'h77; wb_ex.valid = 1'b1; wb_ex.cause = 64'd2;
        tick();
        idle(); check("noack_cvalid", 64'(commit_valid), 64'd0);
        writeback(3'd0, 64'h1); tick();
        idle(); writeback(3'd1, 64'h2); commit_ack = 1'b1; tick();
        idle(); commit_ack = 1'b1; tick();
        idle();
        check("ex_cvalid", 64'(commit_valid), 64'd1);
        check("ex_valid", 64'(commit_entry.ex.valid), 64'd1);
        check("ex_cause", commit_entry.ex.cause, 64'd2);
        check("ex_result", commit_entry.result, 64'h77);

        // Asynchronous reset in the middle of traffic.
        issue_rd(5'd4); tick();
        idle(); rs1 = 5'd4;
        #2 rst_ni = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rst_ni = 1'b1;

        // Randomized traffic against the queue model.
        mq.delete();
        m_tail = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            idle();
            flush       = ($urandom_range(0, 63) == 0);
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_entry.fu        = fu_t'(3'($urandom_range(0, 4)));
            issue_entry.op        = 8'($urandom);
            issue_entry.rs1       = 5'($urandom);
            issue_entry.rs2       = 5'($urandom);
            issue_entry.rd        = 5'($urandom_range(0, 7));
            issue_entry.result    = {$urandom, $urandom};
            issue_entry.valid     = 1'($urandom);
            issue_entry.in_flight = 1'($urandom);
            wb_valid     = ($urandom_range(0, 2) != 0);
            wb_id        = 3'($urandom);
            wb_result    = {$urandom, $urandom};
            wb_ex.valid  = ($urandom_range(0, 7) == 0);
            wb_ex.cause  = 64'($urandom_range(0, 15));
            commit_ack   = 1'($urandom);
            rs1          = 5'($urandom_range(0, 7));
            rs2          = 5'($urandom_range(0, 7));
            #1;
            check("rnd_ready", 64'(issue_ready), 64'(mq.size() < 8));
            check("rnd_tid", 64'(issue_tid), 64'(m_tail));
            check("rnd_cvalid", 64'(commit_valid), 64'(mq.size() > 0 && mq[0].done));
            if (mq.size() > 0 && mq[0].done) begin
                check("rnd_cresult", commit_entry.result, mq[0].result);
                check("rnd_crd", 64'(commit_entry.rd), 64'(mq[0].rd));
                check("rnd_cfu", 64'(commit_entry.fu), 64'(mq[0].fu));
                check("rnd_cop", 64'(commit_entry.op), 64'(mq[0].op));
                check("rnd_cexv", 64'(commit_entry.ex.valid), 64'(mq[0].ex.valid));
                check("rnd_cexc", commit_entry.ex.cause, mq[0].ex.cause);
            end
            m_query(rs1, eb, ev, ef);
            check("rnd_rs1_busy", 64'(rs1_busy), 64'(eb));
            check("rnd_rs1_fv", 64'(rs1_fv), 64'(ev));
            check("rnd_rs1_fwd", rs1_fwd, ef);
            m_query(rs2, eb, ev, ef);
            check("rnd_rs2_busy", 64'(rs2_busy), 64'(eb));
            check("rnd_rs2_fv", 64'(rs2_fv), 64'(ev));
            check("rnd_rs2_fwd", rs2_fwd, ef);
            @(posedge clk);
            m_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

In-order allocate, out-of-order writeback, in-order commit tracker for `ariane_pkg::scoreboard_entry` records, sitting between issue and commit. Issue allocates entries into a circular buffer; functional units (ALU, MULT, LSU, CSR) write results and exceptions back by transaction ID; commit retires the oldest entry once its result is present. The block also answers register hazard queries, either as busy or as forwardable results, so issue can stall or bypass.

## Interface
- `NR_ENTRIES`, 8: buffer depth; power of two, ≥2. `TRANS_ID_BITS` = $clog2(NR_ENTRIES).
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `flush_i` in 1: discard all entries.
- `issue_valid_i` in 1: allocate request.
- `issue_entry_i` in scoreboard_entry: fu, op, rs1, rs2, rd; result, valid, in_flight and ex are ignored.
- `issue_ready_o` out 1: space available.
- `issue_trans_id_o` out TRANS_ID_BITS: ID of the entry the next allocation takes (the tail pointer).
- `rs1_i`, `rs2_i` in 5 each: query registers.
- `rs1_busy_o`, `rs2_busy_o` out 1 each: the youngest writer is still in flight.
- `rs1_fwd_valid_o`, `rs2_fwd_valid_o` out 1 each: the youngest writer has written back.
- `rs1_fwd_o`, `rs2_fwd_o` out 64 each: that writer's result.
- `wb_valid_i` in 1: writeback strobe.
- `wb_trans_id_i` in TRANS_ID_BITS: target entry.
- `wb_result_i` in 64: result.
- `wb_ex_i` in exception: exception record.
- `commit_valid_o` out 1: head entry is complete.
- `commit_entry_o` out scoreboard_entry: head entry.
- `commit_ack_i` in 1: retire the head entry.

## Operation
- State per entry:
  - allocated flag
  - the scoreboard_entry record: `in_flight`=1 from issue until writeback; `valid`=1 after writeback
- State for the buffer: head pointer, tail pointer, and an occupancy count of width TRANS_ID_BITS+1.
- Issue:
  - `issue_ready_o` = count < NR_ENTRIES.
  - On `issue_valid_i && issue_ready_o`: write the record at the tail, set allocated=1, in_flight=1, valid=0, ex.valid=0, result=0; increment the tail, wrapping modulo NR_ENTRIES.
  - `issue_valid_i` while not ready is ignored; no state changes.
- Writeback:
  - On `wb_valid_i`, if the target entry is allocated and in_flight: store result and ex, set valid=1, in_flight=0.
  - Writeback to an unallocated or already-completed entry is ignored.
- Commit:
  - `commit_valid_o` = head entry allocated && valid.
  - `commit_entry_o` = head record; it is driven even when `commit_valid_o`=0.
  - On `commit_ack_i && commit_valid_o`: clear allocated and increment the head. `commit_ack_i` without `commit_valid_o` is ignored.
- Count update: +1 on issue, −1 on commit; an issue and a commit in the same cycle leave the count unchanged.
- Hazard query, per rsX:
  - Scan allocated entries from oldest to youngest and take the youngest with rd==rsX.
  - Busy = that entry is in_flight. Forward valid = that entry is valid, and fwd = its result.
  - rsX==0, or no matching entry: busy=0, fwd_valid=0, fwd=0.
- Flush: clear all allocated flags and zero head, tail and count. Flush has priority over issue, writeback and commit in the same cycle.

## Timing
- Reset and flush leave the outputs at:
  - `issue_ready_o`=1, `issue_trans_id_o`=0
  - `commit_valid_o`=0, `commit_entry_o`=all zeros
  - all busy, fwd_valid and fwd outputs = 0
- All outputs depend combinationally on registered state only. There is no same-cycle bypass of issue or writeback into the outputs.
- Writeback visible to commit and to forwarding: 1 cycle after the `wb_valid_i` edge.
- Issue visible to hazard queries: 1 cycle after the issue edge.
- Full buffer: `issue_ready_o`=0 even when `commit_ack_i` retires an entry in the same cycle. Ready rises the next cycle.
- Simultaneous issue, writeback and commit to distinct entries: all three take effect on the same edge.
- A writeback in the same cycle as the issue of the same ID is ignored, because the entry is not yet allocated.
- Pointers wrap from NR_ENTRIES−1 to 0 with no bubble.

## Test plan
- Reset, then issue three entries with rd=5, 6, 7 → trans IDs 0, 1, 2; `rs1_i`=6 gives busy=1; `commit_valid_o`=0.
- Write back ID 2 (0xC), then ID 0 (0xA) → `commit_valid_o` rises one cycle after ID 0's writeback with result 0xA; ack, and the head becomes ID 1 with `commit_valid_o`=0; `rs1_i`=7 gives fwd_valid=1 and fwd=0xC.
- Two writers of rd=3, ID 0 written back with 0x11 and ID 1 in flight → `rs2_i`=3 gives busy=1, fwd_valid=0; after ID 1 writes back 0x22, fwd=0x22.
- Fill all 8 entries → `issue_ready_o`=0; issue and ack in the same cycle → issue ignored, count 7, ready=1 the next cycle; keep streaming to confirm IDs wrap 7→0.
- Write back ID 2 with ex.valid=1 and cause=2 → committed entry carries ex.valid=1 and cause=2; `rs1_i`=0 always gives busy=0.
- Flush with 5 entries pending and a simultaneous issue → next cycle count=0, `issue_trans_id_o`=0, `commit_valid_o`=0; assert `rst_ni` mid-stream → outputs take reset values immediately, asynchronously.
